// File: rtl/cobs_axis_decoder.sv
// COBS decoder: 8-bit encoded AXI-Stream in, M_DATA_WIDTH-bit little-endian words out.
// The newest complete word is held back until the next byte reveals whether it ends the frame.
module cobs_axis_decoder #(
   parameter int unsigned M_DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              s_axis_tdata,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic                    m_axis_tlast,
   output logic                    m_axis_tuser,
   output logic                    frame_error
);

   localparam int unsigned LANES = M_DATA_WIDTH / 8;
   localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   typedef enum logic [1:0] {StIdle, StData, StCode} state_e;

   state_e                  r_state, w_state_nxt;
   logic [7:0]              r_remaining, w_remaining_nxt;
   logic                    r_zero_pend, w_zero_pend_nxt;
   logic [LW-1:0]           r_lane, w_lane_nxt;
   logic [M_DATA_WIDTH-1:0] r_asm, w_asm_nxt;
   logic [M_DATA_WIDTH-1:0] r_pend, w_pend_nxt;
   logic                    r_pend_valid, w_pend_valid_nxt;
   logic                    r_rdy;
   logic [M_DATA_WIDTH-1:0] r_m_tdata;
   logic                    r_m_tvalid, r_m_tlast, r_m_tuser, r_frame_error;

   logic                    w_acc, w_emit, w_reload, w_err, w_push, w_push_last, w_push_user;
   logic [7:0]              w_emit_byte;
   logic [M_DATA_WIDTH-1:0] w_push_data;

   assign w_acc = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= StIdle;
         r_remaining   <= '0;
         r_zero_pend   <= 1'b0;
         r_lane        <= '0;
         r_asm         <= '0;
         r_pend        <= '0;
         r_pend_valid  <= 1'b0;
         r_rdy         <= 1'b0;
         r_m_tdata     <= '0;
         r_m_tvalid    <= 1'b0;
         r_m_tlast     <= 1'b0;
         r_m_tuser     <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_remaining   <= w_remaining_nxt;
         r_zero_pend   <= w_zero_pend_nxt;
         r_lane        <= w_lane_nxt;
         r_asm         <= w_asm_nxt;
         r_pend        <= w_pend_nxt;
         r_pend_valid  <= w_pend_valid_nxt;
         r_rdy         <= 1'b1;
         r_frame_error <= w_err;
         if (w_push) begin
            r_m_tdata  <= w_push_data;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_push_last;
            r_m_tuser  <= w_push_user;
         end else if (m_axis_tready) begin
            r_m_tvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_remaining_nxt  = r_remaining;
      w_zero_pend_nxt  = r_zero_pend;
      w_lane_nxt       = r_lane;
      w_asm_nxt        = r_asm;
      w_pend_nxt       = r_pend;
      w_pend_valid_nxt = r_pend_valid;
      w_emit           = 1'b0;
      w_emit_byte      = 8'h00;
      w_reload         = 1'b0;
      w_err            = 1'b0;
      w_push           = 1'b0;
      w_push_data      = r_pend;
      w_push_last      = 1'b0;
      w_push_user      = 1'b0;

      if (w_acc) begin
         unique case (r_state)
            StIdle: w_reload = (s_axis_tdata != 8'h00);
            StData: begin
               if (s_axis_tdata != 8'h00) begin
                  w_emit          = 1'b1;
                  w_emit_byte     = s_axis_tdata;
                  w_remaining_nxt = r_remaining - 8'd1;
                  if (r_remaining == 8'd1) w_state_nxt = StCode;
               end else begin
                  w_err = 1'b1;
               end
            end
            StCode: begin
               if (s_axis_tdata == 8'h00) begin
                  if (r_lane != '0) begin
                     w_err = 1'b1;
                  end else begin
                     w_push      = r_pend_valid;
                     w_push_last = 1'b1;
                     w_pend_valid_nxt = 1'b0;
                     w_state_nxt = StIdle;
                  end
               end else begin
                  w_emit   = r_zero_pend;
                  w_reload = 1'b1;
               end
            end
            default: w_state_nxt = StIdle;
         endcase
      end

      if (w_reload) begin
         w_remaining_nxt = s_axis_tdata - 8'd1;
         w_zero_pend_nxt = (s_axis_tdata != 8'hFF);
         w_state_nxt     = (s_axis_tdata == 8'h01) ? StCode : StData;
      end

      if (w_err) begin
         w_push           = r_pend_valid;
         w_push_last      = 1'b1;
         w_push_user      = 1'b1;
         w_lane_nxt       = '0;
         w_pend_valid_nxt = 1'b0;
         w_state_nxt      = StIdle;
      end

      if (w_emit) begin
         w_asm_nxt[int'(r_lane) * 8 +: 8] = w_emit_byte;
         if (r_lane == LAST_LANE) begin
            // Displaced pending word cannot be the last of the frame.
            w_push           = r_pend_valid;
            w_push_last      = 1'b0;
            w_pend_nxt       = w_asm_nxt;
            w_pend_valid_nxt = 1'b1;
            w_lane_nxt       = '0;
         end else begin
            w_lane_nxt = r_lane + LW'(1);
         end
      end
   end

   always_comb begin
      s_axis_tready = r_rdy & (~r_m_tvalid | m_axis_tready);
      m_axis_tdata  = r_m_tdata;
      m_axis_tvalid = r_m_tvalid;
      m_axis_tlast  = r_m_tlast;
      m_axis_tuser  = r_m_tuser;
      frame_error   = r_frame_error;
   end

endmodule

// File: tb/tb_cobs_axis_decoder.sv
// Scoreboard bench for cobs_axis_decoder: directed frames then randomized frames with stalls,
// checked against a byte-level COBS reference decode.
module tb_cobs_axis_decoder;

   localparam int W = 16;
   localparam int L = W / 8;

   typedef logic [7:0] byte_q_t[$];
   typedef struct packed {
      logic [W-1:0] data;
      logic         last;
      logic         user;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [7:0]   s_axis_tdata = 8'h00;
   logic         s_axis_tvalid = 1'b0;
   logic         s_axis_tready;
   logic [W-1:0] m_axis_tdata;
   logic         m_axis_tvalid;
   logic         m_axis_tready = 1'b0;
   logic         m_axis_tlast;
   logic         m_axis_tuser;
   logic         frame_error;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass = 0;
   int   exp_err = 0;
   int   obs_err = 0;
   bit   rnd_ready = 0;
   bit   rnd_gap = 0;
   bit   mon_on = 0;

   cobs_axis_decoder #(.M_DATA_WIDTH(W)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tuser  (m_axis_tuser),
      .frame_error   (frame_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference: plain COBS group walk, then split decoded bytes into words.
   function automatic void ref_decode(input byte_q_t f);
      logic [7:0] d[$];
      int         i;
      int         code;
      int         nw;
      bit         err;
      exp_t       e;
      i = 0;
      err = 0;
      while (i < f.size() && !err) begin
         code = int'(f[i]);
         for (int k = 1; k < code; k++) begin
            if (i + k >= f.size()) begin
               err = 1;
               break;
            end
            d.push_back(f[i + k]);
         end
         if (!err && code != 255 && i + code < f.size()) d.push_back(8'h00);
         i += code;
      end
      if (d.size() % L != 0) err = 1;
      nw = d.size() / L;
      for (int w = 0; w < nw; w++) begin
         e.data = '0;
         for (int j = 0; j < L; j++) e.data[j * 8 +: 8] = d[w * L + j];
         e.last = (w == nw - 1);
         e.user = (w == nw - 1) && err;
         exp_q.push_back(e);
      end
      if (err) exp_err++;
   endfunction

   task automatic send_byte(input logic [7:0] b);
      bit acc;
      if (rnd_gap && $urandom_range(0, 3) == 0) begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
         end
      end
      @(negedge clk);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = b;
      acc = 0;
      for (int t = 0; t < 1000; t++) begin
         #1;
         acc = s_axis_tready;
         @(posedge clk);
         if (acc) break;
         @(negedge clk);
      end
      if (!acc) begin
         $display("FAIL s_tready_timeout: got 0, expected 1 (t=%0t)", $time);
         $fatal(1, "input stalled");
      end
   endtask

   task automatic send_frame(input byte_q_t f);
      ref_decode(f);
      foreach (f[i]) send_byte(f[i]);
      send_byte(8'h00);
   endtask

   task automatic gen_frame(output byte_q_t f);
      int ng;
      int nd;
      logic [7:0] code;
      f = {};
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
         code = ($urandom_range(0, 79) == 0) ? 8'hFF : 8'($urandom_range(1, 6));
         f.push_back(code);
         nd = int'(code) - 1;
         if (g == ng - 1 && $urandom_range(0, 3) == 0) nd = $urandom_range(0, nd);
         for (int k = 0; k < nd; k++) f.push_back(8'($urandom_range(1, 255)));
      end
   endtask

   task automatic drain();
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         #3;
         if (exp_q.size() == 0 && !m_axis_tvalid) break;
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin : ready_drv
      forever begin
         @(negedge clk);
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin : monitor
      bit           stall_p;
      logic [W-1:0] d_p;
      logic         l_p;
      logic         u_p;
      exp_t         e;
      stall_p = 0;
      forever begin
         @(negedge clk);
         #2;
         if (mon_on) begin
            if (frame_error) obs_err++;
            if (stall_p)
               chk("stall_hold", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser},
                   {1'b1, d_p, l_p, u_p});
            if (m_axis_tvalid && m_axis_tready) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", exp_q.size(), 1);
               end else begin
                  e = exp_q.pop_front();
                  chk("word", {m_axis_tdata, m_axis_tlast, m_axis_tuser},
                      {e.data, e.last, e.user});
               end
            end
            stall_p = m_axis_tvalid && !m_axis_tready;
            d_p = m_axis_tdata;
            l_p = m_axis_tlast;
            u_p = m_axis_tuser;
         end
      end
   end

   initial begin : main
      byte_q_t f;
      #12;
      chk("rst_s_tready", s_axis_tready, 0);
      chk("rst_m_tvalid", m_axis_tvalid, 0);
      chk("rst_m_tdata", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, 0);
      chk("rst_frame_error", frame_error, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("tready_after_reset", s_axis_tready, 1);
      mon_on = 1;

      f = '{8'h01, 8'h03, 8'h11, 8'h22, 8'h01};
      send_frame(f);
      drain();
      chk("no_error_clean_frame", obs_err, 0);
      f = '{8'h03, 8'hAA, 8'hBB};
      send_frame(f);
      f = {};
      send_frame(f);
      f = '{8'h04, 8'hAA, 8'hBB, 8'hCC};
      send_frame(f);
      f = '{8'h05, 8'hAA};
      send_frame(f);
      f = '{8'h03, 8'h01, 8'h02};
      send_frame(f);
      f = {8'hFF};
      for (int k = 1; k <= 254; k++) f.push_back(8'(k));
      f.push_back(8'h01);
      send_frame(f);
      drain();
      chk("directed_drain", exp_q.size(), 0);
      chk("directed_error_count", obs_err, exp_err);

      rnd_ready = 1;
      rnd_gap = 1;
      for (int n = 0; n < 1000; n++) begin
         gen_frame(f);
         send_frame(f);
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      rnd_ready = 0;
      drain();
      chk("final_drain", exp_q.size(), 0);
      chk("final_error_count", obs_err, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
